// File: rtl/byte_unstriping_if.sv
// ---------------------------------------------------------------------------
// byte_unstriping_if
// Bundles the four-lane receive word, its valid strobe and the reassembled
// serial byte stream of byte_unstriping.
//   rx_lane0..3 : lane bytes, lane0 is the first byte in stream order
//   rx_ValidL   : the four lane bytes form one word this cycle
//   rx_DataS    : reassembled serial byte (registered in the design)
//   rx_ValidS   : rx_DataS carries a stream byte
//   overflow    : sticky, a lane word was dropped
// master = lane source / stream sink, slave = the unstriping block.
// ---------------------------------------------------------------------------
interface byte_unstriping_if;
  logic [7:0] rx_lane0;
  logic [7:0] rx_lane1;
  logic [7:0] rx_lane2;
  logic [7:0] rx_lane3;
  logic       rx_ValidL;
  logic [7:0] rx_DataS;
  logic       rx_ValidS;
  logic       overflow;

  modport master (
    output rx_lane0, rx_lane1, rx_lane2, rx_lane3, rx_ValidL,
    input  rx_DataS, rx_ValidS, overflow
  );

  modport slave (
    input  rx_lane0, rx_lane1, rx_lane2, rx_lane3, rx_ValidL,
    output rx_DataS, rx_ValidS, overflow
  );
endinterface

// File: rtl/byte_unstriping.sv
// ---------------------------------------------------------------------------
// byte_unstriping
// Captures 4-byte lane words into a 2-entry word FIFO and re-serialises them
// one byte per enabled cycle, lane0 first, with no bubbles between words.
//   clk   : single clock, rising edge
//   rst   : asynchronous, active-low reset
//   enb   : block enable; 0 freezes all internal state and idles the output
//   bus   : byte_unstriping_if.slave (lane words in, serial stream out)
// Parameter INACTIVE is driven on rx_DataS whenever rx_ValidS is 0.
// ---------------------------------------------------------------------------
module byte_unstriping #(
  parameter logic [7:0] INACTIVE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  byte_unstriping_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SER  = 1'b1
  } state_t;

  // Word FIFO
  logic [31:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  // Serializer
  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_overflow;

  logic [31:0] w_in_word;
  logic [31:0] w_head_word;
  logic [1:0]  w_idx;
  logic [7:0]  w_emit_byte;
  logic        w_emit;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic [1:0]  w_count_next;

  always_comb begin
    // NOTE: every signal here is assigned on every path through the block,
    // so no latch can be inferred.
    w_in_word    = {bus.rx_lane3, bus.rx_lane2, bus.rx_lane1, bus.rx_lane0};
    w_head_word  = r_mem[r_rd_ptr];
    // IDLE always starts a word at lane0; SER continues at the held index.
    w_idx        = (r_state == S_SER) ? r_cnt : 2'd0;
    w_emit_byte  = w_head_word[{w_idx, 3'b000} +: 8];
    // A word stays in the FIFO until its lane3 byte goes out, so a non-empty
    // FIFO is exactly the condition for having a byte to emit.
    w_emit       = enb && (r_count != 2'd0);
    w_pop        = w_emit && (w_idx == 2'd3);
    w_push_req   = enb && bus.rx_ValidL;
    // A full FIFO still accepts a word on the edge that frees the head slot.
    w_push       = w_push_req && ((r_count != 2'd2) || w_pop);
    w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // NOTE: the FIFO storage has no reset; the count and pointers define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed in the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_data     <= INACTIVE;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;

      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end

      if (w_emit) begin
        r_data  <= w_emit_byte;
        r_valid <= 1'b1;
        if (w_pop) begin
          // Stay in SER when another word is queued so its lane0 follows
          // immediately; otherwise go back to IDLE.
          r_cnt   <= 2'd0;
          r_state <= (w_count_next != 2'd0) ? S_SER : S_IDLE;
        end else begin
          r_cnt   <= w_idx + 2'd1;
          r_state <= S_SER;
        end
      end else begin
        r_data  <= INACTIVE;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_DataS  = r_data;
  assign bus.rx_ValidS = r_valid;
  assign bus.overflow  = r_overflow;

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 Parameter: INACTIVE, default 8'h00, value driven on rx_DataS whenever rx_ValidS is 0.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: enb  input  1  block enable; 0 freezes all internal state.
REQ-005 Port: rx_lane0  input  8  lane 0 byte; first byte of the word in stream order.
REQ-006 Port: rx_lane1  input  8  lane 1 byte; second byte.
REQ-007 Port: rx_lane2  input  8  lane 2 byte; third byte.
REQ-008 Port: rx_lane3  input  8  lane 3 byte; fourth byte.
REQ-009 Port: rx_ValidL  input  1  lane word valid; 1 marks the four lane bytes as one word this cycle.
REQ-010 Port: rx_DataS  output  8  reassembled serial byte stream, registered.
REQ-011 Port: rx_ValidS  output  1  1 when rx_DataS carries a stream byte, registered.
REQ-012 Port: overflow  output  1  sticky flag, set when a lane word is dropped.

Function
REQ-013 Capture: a rising edge with enb=1 and rx_ValidL=1 shall push {rx_lane3,rx_lane2,rx_lane1,rx_lane0} into a 2-entry word FIFO if it is not full.
REQ-014 Drop: a push attempt while the FIFO is full and no pop happens on the same edge shall discard the word and set overflow to 1.
REQ-015 overflow shall hold 1 until reset.
REQ-016 Simultaneous push and pop on a full FIFO shall accept the pushed word and leave the count at 2.
REQ-017 Serializer FSM states:
- IDLE: no word being emitted.
- SER: emitting byte index cnt, a 2-bit counter.
REQ-018 IDLE -> SER on an enabled edge with the FIFO non-empty; that edge loads rx_lane0 of the head word into rx_DataS, sets rx_ValidS=1, and sets cnt=1.
REQ-019 In SER, each enabled edge shall load the head byte at index cnt into rx_DataS with rx_ValidS=1 and increment cnt; cnt wraps 3 -> 0.
REQ-020 Pop: the edge that loads byte index 3 shall pop the head word from the FIFO.
REQ-021 After a pop, the next edge behaves as follows:
- if another word is present, it emits that word's lane0 byte, back-to-back with no idle cycle;
- otherwise, the FSM returns to IDLE.
REQ-022 Latency: a word captured at edge N shall appear on rx_DataS as lane0, lane1, lane2, lane3 after edges N+1, N+2, N+3, N+4.
REQ-023 Sustained throughput: one word per 4 cycles with zero bubbles and no overflow.
REQ-024 Idle output: any edge that emits no byte shall drive rx_ValidS=0 and rx_DataS=INACTIVE.
REQ-025 enb=0 on an edge shall:
- hold FIFO contents, FSM state, cnt and overflow;
- ignore rx_ValidL, so no push and no overflow;
- drive rx_ValidS=0 and rx_DataS=INACTIVE.
REQ-026 When enb returns to 1, serialization shall resume at the held cnt without losing or repeating bytes.
REQ-027 A word captured at an edge shall not be emitted on that same edge.

Reset
REQ-028 rst=0 shall immediately, independent of clk, force rx_DataS=INACTIVE, rx_ValidS=0, overflow=0, the FIFO empty, cnt=0 and the FSM to IDLE.
REQ-029 Reset asserted mid-word shall discard all partially emitted and buffered words; no residual bytes shall appear after release.
REQ-030 The first enabled edge after rst returns to 1 shall follow REQ-013 to REQ-027 normally.

Verification
REQ-031 Single word: lanes 11,22,33,44 with rx_ValidL at edge 1 -> rx_DataS 11,22,33,44 valid after edges 2-5, then rx_ValidS=0 with rx_DataS=00.
REQ-032 Streaming: words A0..A3 at edge 1 and B0..B3 at edge 5 -> 8 contiguous valid bytes A0,A1,A2,A3,B0,B1,B2,B3 after edges 2-9, overflow=0.
REQ-033 Overflow: words W1, W2, W3 at edges 1, 2, 3 -> W3 dropped, overflow=1 from edge 3 on, only the 8 bytes of W1 and W2 emitted.
REQ-034 Push on pop: W1 at edge 1, W2 at edge 2, W3 at edge 5 (the W1 lane3 edge) -> W3 accepted, overflow=0, 12 contiguous bytes.
REQ-035 Enable stall: enb=0 for 3 cycles after lane1 of 11,22,33,44 is emitted -> rx_ValidS=0 during the stall, then 33 and 44 follow with no duplicate.
REQ-036 Async reset: rst low between edges during serialization -> outputs become 00/0/0 before the next edge; no bytes are emitted after release until a new rx_ValidL.
